fp_mul_issue_ctrl: RTL

- Wraps the fixed-latency pipelined single-precision FP multiplier, which has no valid/ready handshake.
- Upstream side: accepts operand pairs over valid/ready and drives them onto the multiplier's dataa/datab inputs.
- Internal tracking: follows each operation through the multiplier with a valid/tag delay line.
- Downstream side: captures each result into an output FIFO that drains over valid/ready.
- Credit-based admission guarantees no result is ever dropped, even under full downstream backpressure.

---
 rtl/fp_mul_issue_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fp_mul_issue_ctrl.sv
// Issue/return controller around a fixed-latency pipelined FP multiplier.
// Operands are accepted over valid/ready, held in the operand registers,
// and tracked through the multiplier by a valid/tag delay line. Each result
// is captured into a show-ahead FIFO. Admission is credit based: occupancy
// counts in-flight plus buffered operations and never exceeds DEPTH, so a
// capture always finds room even under full downstream backpressure.
module fp_mul_issue_ctrl #(
    parameter int LATENCY = 6,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_a,
    input  logic [31:0]                  in_b,
    input  logic [TAG_W-1:0]             in_tag,
    output logic [31:0]                  mul_dataa,
    output logic [31:0]                  mul_datab,
    input  logic [31:0]                  mul_result,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_result,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    logic [31:0]      mul_dataa_q, mul_dataa_d;
    logic [31:0]      mul_datab_q, mul_datab_d;
    logic             vld_q      [0:LATENCY];
    logic             vld_d      [0:LATENCY];
    logic [TAG_W-1:0] tag_line_q [0:LATENCY];
    logic [TAG_W-1:0] tag_line_d [0:LATENCY];
    logic [31:0]      fifo_res_q [DEPTH];
    logic [31:0]      fifo_res_d [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [DEPTH];
    logic [TAG_W-1:0] fifo_tag_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;

    logic [AW:0]      count;
    logic             accept;
    logic             pop;
    logic             capture;

    // Handshake decode; in_ready depends on registered occupancy only.
    always_comb begin
        count     = wr_ptr_q - rd_ptr_q;
        in_ready  = (occ_q < DEPTH_OCC);
        out_valid = (count != '0);
        accept    = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
        capture   = vld_q[LATENCY] && !flush;
    end

    assign mul_dataa  = mul_dataa_q;
    assign mul_datab  = mul_datab_q;
    assign out_result = fifo_res_q[rd_ptr_q[AW-1:0]];
    assign out_tag    = fifo_tag_q[rd_ptr_q[AW-1:0]];
    assign occupancy  = occ_q;

    // Next-state: operand load, delay-line shift, FIFO write/read, credits.
    always_comb begin
        mul_dataa_d = mul_dataa_q;
        mul_datab_d = mul_datab_q;
        vld_d       = vld_q;
        tag_line_d  = tag_line_q;
        fifo_res_d  = fifo_res_q;
        fifo_tag_d  = fifo_tag_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;

        if (accept) begin
            mul_dataa_d   = in_a;
            mul_datab_d   = in_b;
            tag_line_d[0] = in_tag;
        end
        vld_d[0] = accept;

        // The line never stalls; flush kills every tracked operation so
        // products still inside the multiplier are never captured.
        for (int i = 1; i <= LATENCY; i++) begin
            vld_d[i]      = vld_q[i-1] && !flush;
            tag_line_d[i] = tag_line_q[i-1];
        end

        if (capture) begin
            fifo_res_d[wr_ptr_q[AW-1:0]] = mul_result;
            fifo_tag_d[wr_ptr_q[AW-1:0]] = tag_line_q[LATENCY];
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end
    end

    // State registers with asynchronous clear of everything, storage included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_dataa_q <= '0;
            mul_datab_q <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                vld_q[i]      <= 1'b0;
                tag_line_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fifo_res_q[i] <= '0;
                fifo_tag_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mul_dataa_q <= mul_dataa_d;
            mul_datab_q <= mul_datab_d;
            vld_q       <= vld_d;
            tag_line_q  <= tag_line_d;
            fifo_res_q  <= fifo_res_d;
            fifo_tag_q  <= fifo_tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    // Credit accounting must make a capture into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && (count == DEPTH_CNT)));

endmodule
